// File: rtl/elc_pkg.sv
// Shared state encoding, direction constants and pending-bitmap helpers
// for the elc_scan_ctrl elevator controller.
package elc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } elc_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Helpers work on a maximum-size bitmap; callers zero-extend their pending vector.
  localparam int MAX_FLOORS = 256;
  localparam logic [MAX_FLOORS-1:0] FLOOR_ONE = {{(MAX_FLOORS-1){1'b0}}, 1'b1};

  function automatic logic any_above(input logic [MAX_FLOORS-1:0] pend,
                                     input int unsigned flr);
    return |(pend >> (flr + 1));
  endfunction

  function automatic logic any_below(input logic [MAX_FLOORS-1:0] pend,
                                     input int unsigned flr);
    return |(pend & ((FLOOR_ONE << flr) - FLOOR_ONE));
  endfunction

endpackage

// File: rtl/elc_cycle_timer.sv
// Loadable down-counter: load restarts it at load_val, it then counts to zero and
// holds; done is high while the count is zero.
module elc_cycle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/elc_scan_ctrl.sv
// SCAN-order elevator controller: latches floor requests, sweeps up/down serving them,
// times travel and door dwell. Optional fire recall is enabled by ELC_FIRE_RECALL_EN.
module elc_scan_ctrl
  import elc_pkg::*;
#(
  parameter int N_FLOORS   = 8,
  parameter int FLOOR_W    = $clog2(N_FLOORS),
  parameter int TRAVEL_CYC = 5000,
  parameter int DOOR_CYC   = 5000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [FLOOR_W-1:0]  req_floor,
  input  logic                over_time,
  input  logic                over_weight,
`ifdef ELC_FIRE_RECALL_EN
  input  logic                fire_recall,
`endif
  output logic [FLOOR_W-1:0]  cur_floor,
  output logic                direction,
  output logic                moving,
  output logic                door_open,
  output logic                complete,
  output logic                door_alert,
  output logic                weight_alert,
  output logic [N_FLOORS-1:0] pending
);

  localparam int MAX_CYC = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0]    TRV_LOAD  = CNT_W'(TRAVEL_CYC - 1);
  localparam logic [CNT_W-1:0]    DWL_LOAD  = CNT_W'(DOOR_CYC - 1);
  localparam logic [FLOOR_W-1:0]  TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);
  localparam logic [N_FLOORS-1:0] ONE_HOT0  = {{(N_FLOORS-1){1'b0}}, 1'b1};

  elc_state_t          state, state_nxt;
  logic [FLOOR_W-1:0]  floor_nxt, step_floor;
  logic                dir_nxt, go_up;
  logic [N_FLOORS-1:0] pend_nxt, pend_m, set_mask, clr_mask, cur_mask, arr_mask;
  logic                stop_pend, stop_nxt, complete_nxt;
  logic                trv_load, dwl_load, trv_done, dwl_done;
  logic                alert_now, req_ok, req_here, at_end, arr_hit;
  logic                up_cur, dn_cur, up_new, dn_new;

  elc_cycle_timer #(.CNT_W(CNT_W)) u_travel (
    .clk(clk), .reset(reset), .load(trv_load), .load_val(TRV_LOAD), .done(trv_done)
  );

  elc_cycle_timer #(.CNT_W(CNT_W)) u_dwell (
    .clk(clk), .reset(reset), .load(dwl_load), .load_val(DWL_LOAD), .done(dwl_done)
  );

  assign alert_now  = over_time | over_weight;
  assign req_ok     = req_valid && (32'(req_floor) < N_FLOORS);
  // A call for the floor the car is parked at opens the door instead of queueing.
  assign req_here   = req_ok && (req_floor == cur_floor) &&
                      ((state == IDLE) || (state == DOOR_OPEN));
  assign set_mask   = (req_ok && !req_here) ? (ONE_HOT0 << req_floor) : '0;
  assign pend_m     = pending | set_mask;
  assign step_floor = (state == MOVE_UP) ? cur_floor + 1'b1 : cur_floor - 1'b1;
  assign cur_mask   = ONE_HOT0 << cur_floor;
  assign arr_mask   = ONE_HOT0 << step_floor;
  assign arr_hit    = |(pend_m & arr_mask);
  assign at_end     = ((state == MOVE_UP) && (cur_floor == TOP_FLOOR)) ||
                      ((state == MOVE_DOWN) && (cur_floor == '0));
  assign up_cur     = any_above(MAX_FLOORS'(pend_m), 32'(cur_floor));
  assign dn_cur     = any_below(MAX_FLOORS'(pend_m), 32'(cur_floor));
  assign up_new     = any_above(MAX_FLOORS'(pend_m), 32'(step_floor));
  assign dn_new     = any_below(MAX_FLOORS'(pend_m), 32'(step_floor));

  assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
  assign door_open = (state == DOOR_OPEN);

  always_comb begin
    state_nxt = state;
    floor_nxt = cur_floor;
    dir_nxt   = direction;
    stop_nxt  = 1'b0;
    trv_load  = 1'b0;
    dwl_load  = 1'b0;
    clr_mask  = '0;
    go_up     = direction;
    case (state)
      IDLE: begin
        if (req_here || ((pending != '0) && !up_cur && !dn_cur)) begin
          state_nxt = DOOR_OPEN;
          dwl_load  = 1'b1;
          clr_mask  = cur_mask;
        end else if (pending != '0) begin
          go_up     = (direction == DIR_UP) ? up_cur : !dn_cur;
          state_nxt = go_up ? MOVE_UP : MOVE_DOWN;
          dir_nxt   = go_up ? DIR_UP : DIR_DOWN;
          trv_load  = 1'b1;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        stop_nxt = stop_pend | alert_now;
        if (trv_done) begin
          if (at_end) begin
            state_nxt = DOOR_OPEN;
            dwl_load  = 1'b1;
            stop_nxt  = 1'b0;
          end else begin
            floor_nxt = step_floor;
            // An alert seen during the step forces a stop at the floor just reached.
            if (stop_pend || alert_now || arr_hit ||
                !((state == MOVE_UP) ? up_new : dn_new)) begin
              state_nxt = DOOR_OPEN;
              dwl_load  = 1'b1;
              clr_mask  = arr_mask;
              stop_nxt  = 1'b0;
            end else begin
              trv_load = 1'b1;
            end
          end
        end
      end
      DOOR_OPEN: begin
        if (req_here) begin
          dwl_load = 1'b1;
        end else if (dwl_done && !alert_now) begin
          if ((direction == DIR_UP) ? up_cur : dn_cur) begin
            state_nxt = (direction == DIR_UP) ? MOVE_UP : MOVE_DOWN;
            trv_load  = 1'b1;
          end else if ((direction == DIR_UP) ? dn_cur : up_cur) begin
            state_nxt = (direction == DIR_UP) ? MOVE_DOWN : MOVE_UP;
            dir_nxt   = !direction;
            trv_load  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    pend_nxt     = pend_m & ~clr_mask;
    complete_nxt = (state_nxt == IDLE) && (pend_nxt == '0);
`ifdef ELC_FIRE_RECALL_EN
    // Recall overrides normal service: finish the current step, run non-stop to floor 0.
    if (fire_recall) begin
      state_nxt    = state;
      floor_nxt    = cur_floor;
      dir_nxt      = direction;
      stop_nxt     = 1'b0;
      trv_load     = 1'b0;
      dwl_load     = 1'b0;
      pend_nxt     = '0;
      complete_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (cur_floor != '0) begin
            state_nxt = MOVE_DOWN;
            dir_nxt   = DIR_DOWN;
            trv_load  = 1'b1;
          end else begin
            state_nxt = DOOR_OPEN;
            dwl_load  = 1'b1;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (trv_done) begin
            floor_nxt = at_end ? cur_floor : step_floor;
            if (floor_nxt == '0) begin
              state_nxt = DOOR_OPEN;
              dwl_load  = 1'b1;
            end else begin
              state_nxt = MOVE_DOWN;
              dir_nxt   = DIR_DOWN;
              trv_load  = 1'b1;
            end
          end
        end
        DOOR_OPEN: begin
          if ((cur_floor != '0) && dwl_done && !alert_now) begin
            state_nxt = MOVE_DOWN;
            dir_nxt   = DIR_DOWN;
            trv_load  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cur_floor    <= '0;
      direction    <= DIR_UP;
      pending      <= '0;
      stop_pend    <= 1'b0;
      complete     <= 1'b1;
      door_alert   <= 1'b0;
      weight_alert <= 1'b0;
    end else begin
      state        <= state_nxt;
      cur_floor    <= floor_nxt;
      direction    <= dir_nxt;
      pending      <= pend_nxt;
      stop_pend    <= stop_nxt;
      complete     <= complete_nxt;
      door_alert   <= over_time;
      weight_alert <= over_weight;
    end
  end

endmodule

// File: tb/tb_elc_scan_ctrl.sv
// Directed bench for elc_scan_ctrl with N_FLOORS=8, TRAVEL_CYC=4, DOOR_CYC=6; FLOOR_W is
// widened to 4 so that out-of-range floor indices can be driven.
module tb_elc_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [3:0] req_floor;
  logic       over_time;
  logic       over_weight;
`ifdef ELC_FIRE_RECALL_EN
  logic       fire_recall = 1'b0;
`endif
  logic [3:0] cur_floor;
  logic       direction, moving, door_open, complete, door_alert, weight_alert;
  logic [7:0] pending;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  elc_scan_ctrl #(
    .N_FLOORS(8), .FLOOR_W(4), .TRAVEL_CYC(4), .DOOR_CYC(6)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
    .over_time(over_time), .over_weight(over_weight),
`ifdef ELC_FIRE_RECALL_EN
    .fire_recall(fire_recall),
`endif
    .cur_floor(cur_floor), .direction(direction), .moving(moving), .door_open(door_open),
    .complete(complete), .door_alert(door_alert), .weight_alert(weight_alert),
    .pending(pending)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 1'b0; req_floor = 4'd0; over_time = 1'b0; over_weight = 1'b0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_floor = 4'd3; over_time = 1'b1; over_weight = 1'b1;
    tick(2);
    checks++; if (cur_floor !== 4'd0) begin failures++; $display("FAIL rst_floor got=%0d want=0", cur_floor); end
    checks++; if (direction !== 1'b1) begin failures++; $display("FAIL rst_dir got=%b want=1", direction); end
    checks++; if ({moving, door_open} !== 2'b00) begin failures++; $display("FAIL rst_move_door got=%b want=00", {moving, door_open}); end
    checks++; if (complete !== 1'b1) begin failures++; $display("FAIL rst_complete got=%b want=1", complete); end
    checks++; if ({door_alert, weight_alert} !== 2'b00) begin failures++; $display("FAIL rst_alerts got=%b want=00", {door_alert, weight_alert}); end
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL rst_pending got=%h want=00", pending); end
    do_reset();
  endtask

  task automatic test_single_request();
    do_reset();
    req_valid = 1'b1; req_floor = 4'd3;
    tick(1);
    req_valid = 1'b0;
    checks++; if (pending !== 8'h08) begin failures++; $display("FAIL single_pend got=%h want=08", pending); end
    checks++; if ({moving, complete} !== 2'b00) begin failures++; $display("FAIL single_idle got=%b want=00", {moving, complete}); end
    tick(1);
    checks++; if ({moving, direction} !== 2'b11) begin failures++; $display("FAIL single_depart got=%b want=11", {moving, direction}); end
    tick(11);
    checks++; if ({moving, cur_floor} !== {1'b1, 4'd2}) begin failures++; $display("FAIL single_enroute got=%b/%0d want=1/2", moving, cur_floor); end
    tick(1);
    checks++; if ({door_open, moving, cur_floor} !== {2'b10, 4'd3}) begin failures++; $display("FAIL single_arrive got=%b%b/%0d want=10/3", door_open, moving, cur_floor); end
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL single_clear got=%h want=00", pending); end
    tick(5);
    checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL single_dwell got=%b want=1", door_open); end
    tick(1);
    checks++; if ({door_open, complete} !== 2'b01) begin failures++; $display("FAIL single_done got=%b want=01", {door_open, complete}); end
  endtask

  task automatic test_scan_sweep();
    do_reset();
    req_valid = 1'b1; req_floor = 4'd6;
    tick(1);
    req_valid = 1'b0;
    tick(13);
    checks++; if ({moving, cur_floor} !== {1'b1, 4'd3}) begin failures++; $display("FAIL sweep_at3 got=%b/%0d want=1/3", moving, cur_floor); end
    req_valid = 1'b1; req_floor = 4'd1;
    tick(1);
    checks++; if (pending !== 8'h42) begin failures++; $display("FAIL sweep_pend got=%h want=42", pending); end
    req_floor = 4'd6;
    tick(1);
    req_valid = 1'b0;
    checks++; if (pending !== 8'h42) begin failures++; $display("FAIL sweep_dup got=%h want=42", pending); end
    tick(10);
    checks++; if ({door_open, direction, cur_floor} !== {2'b11, 4'd6}) begin failures++; $display("FAIL sweep_at6 got=%b%b/%0d want=11/6", door_open, direction, cur_floor); end
    checks++; if (pending !== 8'h02) begin failures++; $display("FAIL sweep_left got=%h want=02", pending); end
    tick(5);
    checks++; if ({door_open, direction} !== 2'b11) begin failures++; $display("FAIL sweep_hold_dir got=%b want=11", {door_open, direction}); end
    tick(1);
    checks++; if ({moving, direction} !== 2'b10) begin failures++; $display("FAIL sweep_reverse got=%b want=10", {moving, direction}); end
    tick(20);
    checks++; if ({door_open, cur_floor, pending} !== {1'b1, 4'd1, 8'h00}) begin failures++; $display("FAIL sweep_at1 got=%b/%0d/%h want=1/1/00", door_open, cur_floor, pending); end
    tick(6);
    checks++; if ({complete, direction} !== 2'b10) begin failures++; $display("FAIL sweep_idle got=%b want=10", {complete, direction}); end
  endtask

  task automatic test_over_time();
    do_reset();
    req_valid = 1'b1; req_floor = 4'd7;
    tick(1);
    req_valid = 1'b0;
    tick(18);
    over_time = 1'b1;
    tick(1);
    over_time = 1'b0;
    checks++; if ({door_alert, moving, cur_floor} !== {2'b11, 4'd4}) begin failures++; $display("FAIL otime_alert got=%b%b/%0d want=11/4", door_alert, moving, cur_floor); end
    tick(1);
    checks++; if ({door_alert, moving} !== 2'b01) begin failures++; $display("FAIL otime_drop got=%b want=01", {door_alert, moving}); end
    tick(1);
    checks++; if ({door_open, cur_floor, pending} !== {1'b1, 4'd5, 8'h80}) begin failures++; $display("FAIL otime_stop got=%b/%0d/%h want=1/5/80", door_open, cur_floor, pending); end
    tick(6);
    checks++; if ({moving, direction} !== 2'b11) begin failures++; $display("FAIL otime_resume got=%b want=11", {moving, direction}); end
  endtask

  task automatic test_over_weight();
    do_reset();
    req_valid = 1'b1; req_floor = 4'd2;
    tick(1);
    req_valid = 1'b0;
    tick(9);
    checks++; if ({door_open, cur_floor} !== {1'b1, 4'd2}) begin failures++; $display("FAIL wgt_at2 got=%b/%0d want=1/2", door_open, cur_floor); end
    req_valid = 1'b1; req_floor = 4'd5; over_weight = 1'b1;
    tick(1);
    req_valid = 1'b0;
    checks++; if ({weight_alert, pending} !== {1'b1, 8'h20}) begin failures++; $display("FAIL wgt_alert got=%b/%h want=1/20", weight_alert, pending); end
    tick(5);
    checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL wgt_hold_early got=%b want=1", door_open); end
    tick(14);
    checks++; if ({door_open, weight_alert} !== 2'b11) begin failures++; $display("FAIL wgt_hold_late got=%b want=11", {door_open, weight_alert}); end
    over_weight = 1'b0;
    tick(1);
    checks++; if ({moving, direction, weight_alert} !== 3'b110) begin failures++; $display("FAIL wgt_depart got=%b want=110", {moving, direction, weight_alert}); end
  endtask

  task automatic test_request_filter();
    do_reset();
    req_valid = 1'b1; req_floor = 4'd9;
    tick(1);
    checks++; if ({pending, complete} !== {8'h00, 1'b1}) begin failures++; $display("FAIL filt_9 got=%h/%b want=00/1", pending, complete); end
    req_floor = 4'd8;
    tick(1);
    checks++; if ({pending, moving} !== {8'h00, 1'b0}) begin failures++; $display("FAIL filt_8 got=%h/%b want=00/0", pending, moving); end
    req_floor = 4'd0;
    tick(1);
    req_valid = 1'b0;
    checks++; if ({door_open, pending} !== {1'b1, 8'h00}) begin failures++; $display("FAIL filt_here got=%b/%h want=1/00", door_open, pending); end
    tick(2);
    req_valid = 1'b1; req_floor = 4'd0;
    tick(1);
    req_valid = 1'b0;
    checks++; if ({door_open, pending} !== {1'b1, 8'h00}) begin failures++; $display("FAIL filt_restart got=%b/%h want=1/00", door_open, pending); end
    tick(5);
    checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL filt_extended got=%b want=1", door_open); end
    tick(1);
    checks++; if ({door_open, complete} !== 2'b01) begin failures++; $display("FAIL filt_close got=%b want=01", {door_open, complete}); end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    req_valid = 1'b1; req_floor = 4'd7;
    tick(1);
    req_floor = 4'd4;
    tick(1);
    req_floor = 4'd5;
    tick(1);
    req_floor = 4'd6;
    tick(1);
    req_valid = 1'b0;
    checks++; if (pending !== 8'hF0) begin failures++; $display("FAIL mid_pend got=%h want=F0", pending); end
    tick(6);
    checks++; if ({moving, cur_floor} !== {1'b1, 4'd2}) begin failures++; $display("FAIL mid_at2 got=%b/%0d want=1/2", moving, cur_floor); end
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if ({cur_floor, pending} !== {4'd0, 8'h00}) begin failures++; $display("FAIL mid_abort got=%0d/%h want=0/00", cur_floor, pending); end
    checks++; if ({moving, door_open, complete, direction} !== 4'b0011) begin failures++; $display("FAIL mid_idle got=%b want=0011", {moving, door_open, complete, direction}); end
  endtask

`ifdef ELC_FIRE_RECALL_EN
  task automatic test_fire_recall();
    do_reset();
    req_valid = 1'b1; req_floor = 4'd7;
    tick(1);
    req_valid = 1'b0;
    tick(21);
    checks++; if ({moving, cur_floor} !== {1'b1, 4'd5}) begin failures++; $display("FAIL fire_at5 got=%b/%0d want=1/5", moving, cur_floor); end
    tick(1);
    fire_recall = 1'b1;
    tick(1);
    checks++; if ({pending, complete} !== {8'h00, 1'b0}) begin failures++; $display("FAIL fire_clear got=%h/%b want=00/0", pending, complete); end
    tick(2);
    checks++; if ({moving, direction, cur_floor} !== {2'b10, 4'd6}) begin failures++; $display("FAIL fire_turn got=%b%b/%0d want=10/6", moving, direction, cur_floor); end
    tick(24);
    checks++; if ({door_open, cur_floor} !== {1'b1, 4'd0}) begin failures++; $display("FAIL fire_lobby got=%b/%0d want=1/0", door_open, cur_floor); end
    tick(10);
    checks++; if ({door_open, complete} !== 2'b10) begin failures++; $display("FAIL fire_hold got=%b want=10", {door_open, complete}); end
    fire_recall = 1'b0;
    tick(1);
    checks++; if ({door_open, complete} !== 2'b01) begin failures++; $display("FAIL fire_release got=%b want=01", {door_open, complete}); end
  endtask
`endif

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_floor = 4'd0; over_time = 1'b0; over_weight = 1'b0;
    test_reset();
    test_single_request();
    test_scan_sweep();
    test_over_time();
    test_over_weight();
    test_request_filter();
    test_reset_mid_move();
`ifdef ELC_FIRE_RECALL_EN
    test_fire_recall();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
